// File: rtl/lcd_arb_pkg.sv
// Shared types and LCD constants for the character-LCD write arbiter.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    PASS,
    DRAIN
  } state_e;

  localparam logic       LCD_ADDR_CMD  = 1'b0;
  localparam logic       LCD_ADDR_DATA = 1'b1;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin picker: the first requester after ptr_i (wrapping) wins.
module lcd_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int GRANT_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [GRANT_W-1:0] idx_o
);

  logic               found;
  logic [GRANT_W-1:0] sel;
  int                 cand;

  // The pointer itself is searched last, so the previous owner has lowest priority.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      sel = GRANT_W'(cand);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares one Avalon-MM character-LCD slave between N_REQ burst writers,
// round-robin, optionally clearing the display before each new owner.
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int INSERT_CLEAR = 1,
  parameter int GRANT_W      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_addr,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 address,
  output logic                 chipselect,
  output logic                 write,
  output logic                 read,
  output logic [7:0]           writedata,
  input  logic                 waitrequest,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic               addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               pend_q, pend_d;

  logic [N_REQ-1:0]   gnt_oh;
  logic [GRANT_W-1:0] gnt_idx;
  logic               completing;
  logic               slotFree;
  logic [7:0]         ownerData;

  lcd_rr_arbiter #(
    .N_REQ   (N_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx)
  );

  assign completing = pend_q & ~waitrequest;
  assign slotFree   = ~pend_q | completing;
  assign ownerData  = req_data[{grant_q, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= GRANT_W'(N_REQ - 1);
      grant_q <= '0;
      addr_q  <= 1'b0;
      data_q  <= 8'h00;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  // A completing beat frees the output register; a beat loaded in the same
  // cycle overrides that, giving back-to-back writes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    data_d    = data_q;
    pend_d    = pend_q;
    req_ready = '0;
    if (completing) pend_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|gnt_oh) begin
          grant_d = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = (INSERT_CLEAR != 0) ? CLEAR : PASS;
        end
      end
      CLEAR: begin
        if (!pend_q) begin
          addr_d = LCD_ADDR_CMD;
          data_d = LCD_CMD_CLEAR;
          pend_d = 1'b1;
        end else if (completing) begin
          state_d = PASS;
        end
      end
      PASS: begin
        req_ready[grant_q] = slotFree;
        if (req_valid[grant_q] && slotFree) begin
          addr_d = req_addr[grant_q];
          data_d = ownerData;
          pend_d = 1'b1;
          if (req_last[grant_q]) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend_q || completing) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign address    = addr_q;
  assign writedata  = data_q;
  assign chipselect = pend_q;
  assign write      = pend_q;
  assign read       = 1'b0;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: per-requester beat queues, a slave-side
// write log and hand-computed expected write sequences.
module tb_lcd_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        address;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [7:0]  writedata;
  logic        waitrequest;
  logic [1:0]  grant_id;
  logic        busy;

  int testsRun  = 0;
  int failCount = 0;

  logic [9:0] beatMem [4][64];
  int         headI [4];
  int         tailI [4];
  bit         accI [4];
  int         pauseAt [4];
  int         pauseLeft [4];
  int         stallAt, stallLeft, stallSeen;
  logic       stallExpAddr;
  logic [7:0] stallExpData;

  logic       logAddr [128];
  logic [7:0] logData [128];
  int         logOwner [128];
  int         logCount;

  int         expOwn4 [12] = '{0, 0, 0, 3, 3, 3, 0, 0, 0, 3, 3, 3};
  logic [7:0] expDat4 [12] = '{8'h01, "a", "b", 8'h01, "e", "f",
                               8'h01, "c", "d", 8'h01, "g", "h"};

  lcd_write_arbiter #(
    .N_REQ        (4),
    .INSERT_CLEAR (1),
    .GRANT_W      (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearDriver();
    for (int i = 0; i < 4; i++) begin
      headI[i]     = tailI[i];
      accI[i]      = 1'b0;
      pauseAt[i]   = -1;
      pauseLeft[i] = 0;
    end
    stallLeft   = 0;
    waitrequest = 1'b0;
  endtask

  task automatic loadBeat(input int r, input logic a, input logic [7:0] d, input logic l);
    beatMem[r][tailI[r] % 64] = {a, l, d};
    tailI[r]++;
  endtask

  // One cycle of requester and slave behaviour, run on each falling edge.
  task automatic applyStimulus();
    logic [3:0]  vV, aV, lV;
    logic [31:0] dV;
    logic [9:0]  beat;
    bit          paused;
    paused = 1'b0;
    vV = '0; aV = '0; lV = '0; dV = '0;
    for (int i = 0; i < 4; i++) begin
      if (accI[i]) headI[i]++;
      accI[i] = 1'b0;
      beat  = beatMem[i][headI[i] % 64];
      vV[i] = (headI[i] < tailI[i]);
      if (vV[i] && pauseLeft[i] > 0 && headI[i] == pauseAt[i]) begin
        vV[i] = 1'b0;
        pauseLeft[i]--;
        paused = 1'b1;
      end
      aV[i] = beat[9];
      lV[i] = beat[8];
      dV[i*8 +: 8] = beat[7:0];
    end
    waitrequest = (stallLeft > 0 && write === 1'b1 && logCount == stallAt);
    if (waitrequest) stallLeft--;
    req_valid = vV;
    req_addr  = aV;
    req_last  = lV;
    req_data  = dV;
    #1;
    for (int i = 0; i < 4; i++) accI[i] = req_valid[i] & req_ready[i];
    if (paused) begin
      checkOutput("pauseGrant", grant_id, 0);
      checkOutput("pauseReady1", req_ready[1], 0);
    end
    if (waitrequest) begin
      stallSeen++;
      checkOutput("stallAddr", address, stallExpAddr);
      checkOutput("stallData", writedata, stallExpData);
      checkOutput("stallReady", req_ready, 0);
    end
    if (write === 1'b1 && waitrequest === 1'b0 && logCount < 128) begin
      logAddr[logCount]  = address;
      logData[logCount]  = writedata;
      logOwner[logCount] = grant_id;
      logCount++;
    end
  endtask

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < 4; i++) begin
      headI[i] = 0;
      tailI[i] = 0;
    end
    stallAt = -1; stallSeen = 0; logCount = 0;
    stallExpAddr = 1'b0; stallExpData = 8'h00;
    clearDriver();
    forever begin
      @(negedge clk);
      applyStimulus();
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitLog(input string tag, input int n);
    int c;
    c = 0;
    while (logCount < n && c < 300) begin
      waitCycles(1);
      c++;
    end
    checkOutput(tag, (logCount >= n), 1);
  endtask

  task automatic expectLog(input string name, input int idx, input logic a,
                           input logic [7:0] d, input int owner);
    checkOutput($sformatf("%s.addr%0d", name, idx), logAddr[idx], a);
    checkOutput($sformatf("%s.data%0d", name, idx), logData[idx], d);
    checkOutput($sformatf("%s.owner%0d", name, idx), logOwner[idx], owner);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    clearDriver();
    waitCycles(2);
    reset_n  = 1'b1;
    logCount = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    waitCycles(1);
    checkOutput("rstChipselect", chipselect, 0);
    checkOutput("rstWrite", write, 0);
    checkOutput("rstRead", read, 0);
    checkOutput("rstAddress", address, 0);
    checkOutput("rstWritedata", writedata, 0);
    checkOutput("rstReady", req_ready, 0);
    checkOutput("rstGrant", grant_id, 0);
    checkOutput("rstBusy", busy, 0);
    waitCycles(1);
    reset_n = 1'b1;
    logCount = 0;

    // Single requester: clear then "HI!"
    loadBeat(0, 1'b1, "H", 1'b0);
    loadBeat(0, 1'b1, "I", 1'b0);
    loadBeat(0, 1'b1, "!", 1'b1);
    waitCycles(2);
    checkOutput("t1BusyMid", busy, 1);
    waitLog("t1Timeout", 4);
    waitCycles(3);
    checkOutput("t1Count", logCount, 4);
    expectLog("t1", 0, 1'b0, 8'h01, 0);
    expectLog("t1", 1, 1'b1, 8'h48, 0);
    expectLog("t1", 2, 1'b1, 8'h49, 0);
    expectLog("t1", 3, 1'b1, 8'h21, 0);
    checkOutput("t1BusyEnd", busy, 0);
    checkOutput("t1WriteEnd", write, 0);

    // Requesters 1 and 2 tie after reset; then pointer should sit at 2
    doReset();
    loadBeat(1, 1'b1, "A", 1'b0);
    loadBeat(1, 1'b1, "B", 1'b1);
    loadBeat(2, 1'b1, "C", 1'b0);
    loadBeat(2, 1'b1, "D", 1'b1);
    waitLog("t2Timeout", 6);
    waitCycles(3);
    checkOutput("t2Count", logCount, 6);
    expectLog("t2", 0, 1'b0, 8'h01, 1);
    expectLog("t2", 1, 1'b1, "A", 1);
    expectLog("t2", 2, 1'b1, "B", 1);
    expectLog("t2", 3, 1'b0, 8'h01, 2);
    expectLog("t2", 4, 1'b1, "C", 2);
    expectLog("t2", 5, 1'b1, "D", 2);
    loadBeat(1, 1'b1, "E", 1'b1);
    loadBeat(3, 1'b1, "F", 1'b1);
    waitLog("t2bTimeout", 8);
    expectLog("t2b", 6, 1'b0, 8'h01, 3);
    expectLog("t2b", 7, 1'b1, "F", 3);
    waitLog("t2cTimeout", 10);
    expectLog("t2c", 9, 1'b1, "E", 1);

    // Waitrequest held for 5 cycles on the second data beat
    waitCycles(3);
    logCount     = 0;
    stallSeen    = 0;
    stallAt      = 2;
    stallLeft    = 5;
    stallExpAddr = 1'b1;
    stallExpData = "y";
    loadBeat(0, 1'b1, "x", 1'b0);
    loadBeat(0, 1'b1, "y", 1'b0);
    loadBeat(0, 1'b1, "z", 1'b1);
    waitLog("t3Timeout", 4);
    waitCycles(4);
    checkOutput("t3StallSeen", stallSeen, 5);
    checkOutput("t3Count", logCount, 4);
    expectLog("t3", 1, 1'b1, "x", 0);
    expectLog("t3", 2, 1'b1, "y", 0);
    expectLog("t3", 3, 1'b1, "z", 0);
    stallAt = -1;

    // Requester 0 keeps bursting while 3 waits: grants must alternate
    doReset();
    loadBeat(0, 1'b1, "a", 1'b0);
    loadBeat(0, 1'b1, "b", 1'b1);
    loadBeat(0, 1'b1, "c", 1'b0);
    loadBeat(0, 1'b1, "d", 1'b1);
    loadBeat(3, 1'b1, "e", 1'b0);
    loadBeat(3, 1'b1, "f", 1'b1);
    loadBeat(3, 1'b1, "g", 1'b0);
    loadBeat(3, 1'b1, "h", 1'b1);
    waitLog("t4Timeout", 12);
    for (int k = 0; k < 12; k++)
      expectLog("t4", k, (k % 3 != 0), expDat4[k], expOwn4[k]);

    // Owner pauses mid-burst for 10 cycles while requester 1 waits
    waitCycles(3);
    logCount   = 0;
    pauseAt[0] = tailI[0] + 1;
    pauseLeft[0] = 10;
    loadBeat(0, 1'b1, "p", 1'b0);
    loadBeat(0, 1'b1, "q", 1'b0);
    loadBeat(0, 1'b1, "r", 1'b1);
    loadBeat(1, 1'b1, "s", 1'b1);
    waitLog("t5Timeout", 6);
    checkOutput("t5PauseDone", pauseLeft[0], 0);
    expectLog("t5", 1, 1'b1, "p", 0);
    expectLog("t5", 2, 1'b1, "q", 0);
    expectLog("t5", 3, 1'b1, "r", 0);
    expectLog("t5", 4, 1'b0, 8'h01, 1);
    expectLog("t5", 5, 1'b1, "s", 1);

    // Reset during a stalled write; pointer returns to 3 so 0 beats 1
    waitCycles(3);
    logCount     = 0;
    stallAt      = 0;
    stallLeft    = 100;
    stallExpAddr = 1'b0;
    stallExpData = 8'h01;
    loadBeat(0, 1'b1, "k", 1'b1);
    begin
      int c;
      c = 0;
      while (waitrequest !== 1'b1 && c < 50) begin
        waitCycles(1);
        c++;
      end
      checkOutput("t6StallReached", waitrequest, 1);
    end
    reset_n = 1'b0;
    clearDriver();
    stallAt = -1;
    #1;
    checkOutput("t6RstChipselect", chipselect, 0);
    checkOutput("t6RstWrite", write, 0);
    checkOutput("t6RstBusy", busy, 0);
    checkOutput("t6RstGrant", grant_id, 0);
    waitCycles(2);
    reset_n  = 1'b1;
    logCount = 0;
    loadBeat(0, 1'b1, "u", 1'b1);
    loadBeat(1, 1'b1, "v", 1'b1);
    waitLog("t6Timeout", 4);
    expectLog("t6", 0, 1'b0, 8'h01, 0);
    expectLog("t6", 1, 1'b1, "u", 0);
    expectLog("t6", 2, 1'b0, 8'h01, 1);
    expectLog("t6", 3, 1'b1, "v", 1);

    waitCycles(3);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single Avalon-MM character-LCD slave (char_display) between N_REQ independent message sources, e.g. per-effect LCD writers such as COLOUR_lcd.
- Each requester streams a burst of write beats with valid/ready handshakes. The arbiter grants round-robin and holds the grant until the beat flagged last is accepted.
- Optionally issues a clear-display command before each new owner's burst. Beats are forwarded to the slave while honouring waitrequest.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- INSERT_CLEAR, 1, when 1 issue command 0x01 at address 0 before every granted burst.
- GRANT_W, $clog2(N_REQ), width of grant_id.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester beat valid
- req_addr  in  N_REQ  per-requester beat address (0 = instruction, 1 = data)
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  marks final beat of a burst
- req_ready  out  N_REQ  beat accepted when valid&ready
- address  out  1  Avalon address to LCD slave
- chipselect  out  1  Avalon chipselect
- write  out  1  Avalon write
- read  out  1  Avalon read, constant 0
- writedata  out  8  Avalon writedata
- waitrequest  in  1  Avalon waitrequest from LCD slave
- grant_id  out  GRANT_W  current/last owner index
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; address, chipselect, write, writedata, req_ready, grant_id, busy all 0.
  - Round-robin pointer=N_REQ-1, so requester 0 has top priority first.
  - An in-flight Avalon write is abandoned.
- Avalon rule:
  - chipselect=write while a beat is pending.
  - address and writedata are registered and held stable while waitrequest=1.
  - A write completes on the cycle write=1 and waitrequest=0. The next cycle, write drops, unless a new beat is loaded in the same cycle (back-to-back allowed).
- States: IDLE, CLEAR, PASS, DRAIN.
- IDLE:
  - If any req_valid is high, select winner w = first index with valid, searching from ptr+1 mod N_REQ.
  - Register grant_id=w and ptr=w.
  - Go to CLEAR if INSERT_CLEAR, else PASS.
  - Arbitration costs 1 cycle. No req_ready is given in IDLE.
- CLEAR:
  - Load the command beat address=0, writedata=0x01. Hold it until completion, then go to PASS.
  - req_ready stays 0 throughout.
- PASS:
  - req_ready[grant_id] = (no beat pending) OR (beat completing this cycle). All other ready bits are 0.
  - An accepted beat is loaded into the output register, giving write=1 on the next cycle. Latency from accept to write is 1 cycle; sustained rate is 1 beat/cycle when waitrequest=0.
  - When the accepted beat has req_last=1, go to DRAIN.
- DRAIN:
  - Wait for the final beat to complete, then return to IDLE.
  - A new grant can begin the cycle after that.
- Owner drops valid mid-burst: the grant is held (no timeout); other requesters wait.
- Simultaneous requests: exactly one winner. Rotation guarantees that each requester waits at most N_REQ-1 bursts.
- A requester raising valid while another owns the grant is not acknowledged until it wins.
- req_addr is passed through unchanged as the LSB. req_data is 8 bits, with no width conversion.
- read is never asserted; readdata and response are ignored.

Decomposition:
- Package lcd_arb_pkg:
  - state enum {IDLE, CLEAR, PASS, DRAIN}
  - LCD_ADDR_CMD=1'b0, LCD_ADDR_DATA=1'b1, LCD_CMD_CLEAR=8'h01
- Sub-module lcd_rr_arbiter:
  - Inputs: request vector and pointer.
  - Outputs: combinational one-hot grant plus encoded index.
- The top holds the FSM, the output register and the ready generation.

Test Plan:
- Single requester 0 sends 3 beats (addr 1, 'H','I','!', last on '!'), waitrequest=0, INSERT_CLEAR=1 -> slave sees (0,0x01),(1,0x48),(1,0x49),(1,0x21) in order; busy returns 0 after the final write.
- Requesters 1 and 2 valid in the same cycle after reset -> requester 1 is served first with its full burst, then 2; grant_id reads 1 then 2; ptr=2 afterwards.
- waitrequest held high 5 cycles on the 2nd beat -> address/writedata stay stable for those 5 cycles, req_ready stays 0, no beat is lost or duplicated.
- Requester 0 issues repeated bursts while requester 3 is valid -> bursts alternate 0,3,0,3; no starvation.
- Owner deasserts valid mid-burst for 10 cycles while requester 1 is valid -> no grant switch; burst resumes and completes before 1 is granted.
- reset_n pulsed low during a pending write with waitrequest=1 -> chipselect/write drop immediately; after release the state is IDLE and requester 0 wins a tie against requester 1.
